// File: rtl/fetch_pkg.sv
// Shared constants, entry layout and sizing helper for the instruction-fetch front end.
package fetch_pkg;

  // Instruction memory is word addressed, so sequential fetch steps the PC by one.
  localparam int PC_INC = 1;

  // Queue entry layout for the default RV32 configuration.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetchEntry_t;

  function automatic int countWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO with flush and a registered head that holds its last value when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                         clock,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             pushData,
  input  logic                         pop,
  input  logic                         flush,
  output logic [countWidth(DEPTH)-1:0] count,
  output logic                         headValid,
  output logic [WIDTH-1:0]             headData
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = countWidth(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    nextRdPtr;
  logic [CW-1:0]    remaining;
  logic [CW-1:0]    nextCount;
  logic             doPush;
  logic             doPop;

  always_comb begin
    doPop     = pop && (count != '0) && !flush;
    doPush    = push && !flush;
    nextRdPtr = rdPtr + PW'(doPop);
    remaining = count - CW'(doPop);
    nextCount = remaining + CW'(doPush);
  end

  assign headValid = (count != '0);

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  // The head register is reloaded from storage, or from the incoming word when the queue drains to it.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      headData <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PW'(1);
      rdPtr <= nextRdPtr;
      count <= nextCount;
      if (remaining != '0) headData <= mem[nextRdPtr];
      else if (doPush)     headData <= pushData;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, one-deep in-flight tracking, credit-based issue, prefetch queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter int               ADDR_W   = 8,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                     clock,
  input  logic                     clear,
  output logic [ADDR_W-1:0]        imem_addr,
  output logic                     imem_req,
  input  logic [XLEN-1:0]          imem_data,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [XLEN-1:0]          id_pc,
  output logic [XLEN-1:0]          id_instr,
  output logic [XLEN-1:0]          id_next_pc,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int CW = countWidth(DEPTH);
  localparam int DW = CW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] fetchPc;
  logic [XLEN-1:0] inflightPc;
  logic            inflight;
  logic            headSeen;
  logic            pop;
  logic            push;
  logic [DW-1:0]   demand;
  entry_t          pushEntry;
  entry_t          headEntry;

  // Handshake: the head entry transfers to decode on any cycle where id_valid and id_ready are
  // both high; id_valid never depends on id_ready, and a redirect in the same cycle cancels it.
  assign pop  = id_valid && id_ready;
  assign push = inflight && !redirect_valid;

  // Credit: queued plus in-flight entries after this cycle's pop must leave room for one more.
  assign demand   = DW'(q_count) + DW'(inflight) - DW'(pop);
  assign imem_req = clear && !redirect_valid && (demand < DW'(DEPTH));

  assign imem_addr = fetchPc[ADDR_W-1:0];

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      fetchPc    <= RESET_PC;
      inflight   <= 1'b0;
      inflightPc <= '0;
      headSeen   <= 1'b0;
    end else begin
      headSeen <= headSeen || id_valid;
      if (redirect_valid) begin
        fetchPc  <= redirect_pc;
        inflight <= 1'b0;
      end else if (imem_req) begin
        fetchPc    <= fetchPc + XLEN'(PC_INC);
        inflight   <= 1'b1;
        inflightPc <= fetchPc;
      end else begin
        inflight <= 1'b0;
      end
    end
  end

  assign pushEntry = {inflightPc, imem_data};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clock     (clock),
    .clear     (clear),
    .push      (push),
    .pushData  (pushEntry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (q_count),
    .headValid (id_valid),
    .headData  (headEntry)
  );

  assign id_pc    = headEntry.pc;
  assign id_instr = headEntry.instr;
  // Stays zero until a first instruction has reached the head, matching the reset value.
  assign id_next_pc = (headSeen || id_valid) ? id_pc + XLEN'(PC_INC) : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an instruction RAM holding 0x100 + address.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic [31:0] imem_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] id_next_pc;
  logic [2:0]  q_count;

  int nCompared   = 0;
  int nMismatched = 0;
  logic [31:0] expQ[$];

  fetch_unit #(.XLEN(32), .ADDR_W(8), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clock          (clock),
    .clear          (clear),
    .imem_addr      (imem_addr),
    .imem_req       (imem_req),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_next_pc     (id_next_pc),
    .q_count        (q_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (imem_req) imem_data <= 32'h100 + {24'h0, imem_addr};
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic applyReset(input logic ready);
    clear = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = ready;
    tick();
    tick();
    clear = 1'b1;
  endtask

  task automatic test_reset;
    clear = 1'b0;
    id_ready = 1'b1;
    tick();
    tick();
    nCompared++; if (id_valid !== 1'b0) begin nMismatched++; $display("FAIL reset_id_valid got %0h want 0", id_valid); end
    nCompared++; if (id_pc !== 32'h0) begin nMismatched++; $display("FAIL reset_id_pc got %0h want 0", id_pc); end
    nCompared++; if (id_instr !== 32'h0) begin nMismatched++; $display("FAIL reset_id_instr got %0h want 0", id_instr); end
    nCompared++; if (id_next_pc !== 32'h0) begin nMismatched++; $display("FAIL reset_id_next_pc got %0h want 0", id_next_pc); end
    nCompared++; if (imem_req !== 1'b0) begin nMismatched++; $display("FAIL reset_imem_req got %0h want 0", imem_req); end
    nCompared++; if (imem_addr !== 8'h0) begin nMismatched++; $display("FAIL reset_imem_addr got %0h want 0", imem_addr); end
    nCompared++; if (q_count !== 3'd0) begin nMismatched++; $display("FAIL reset_q_count got %0d want 0", q_count); end
    clear = 1'b1;
    #1;
    nCompared++; if (imem_req !== 1'b1) begin nMismatched++; $display("FAIL first_issue_req got %0h want 1", imem_req); end
  endtask

  task automatic test_stream;
    tick();
    nCompared++; if (id_valid !== 1'b0) begin nMismatched++; $display("FAIL stream_latency_valid got %0h want 0", id_valid); end
    tick();
    for (int k = 0; k < 8; k++) begin
      nCompared++; if (id_valid !== 1'b1 || id_pc !== 32'(k)) begin nMismatched++; $display("FAIL stream_pc got v=%0h pc=%0h want v=1 pc=%0h", id_valid, id_pc, k); end
      nCompared++; if (id_instr !== 32'h100 + 32'(k)) begin nMismatched++; $display("FAIL stream_instr got %0h want %0h", id_instr, 32'h100 + 32'(k)); end
      nCompared++; if (id_next_pc !== 32'(k + 1)) begin nMismatched++; $display("FAIL stream_next_pc got %0h want %0h", id_next_pc, k + 1); end
      tick();
    end
  endtask

  task automatic test_stall_fill;
    applyReset(1'b0);
    repeat (10) tick();
    nCompared++; if (q_count !== 3'd4) begin nMismatched++; $display("FAIL stall_q_count got %0d want 4", q_count); end
    nCompared++; if (imem_req !== 1'b0) begin nMismatched++; $display("FAIL stall_imem_req got %0h want 0", imem_req); end
    for (int k = 0; k < 8; k++) expQ.push_back(32'(k));
    id_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [31:0] exp;
      exp = expQ.pop_front();
      nCompared++; if (id_valid !== 1'b1 || id_pc !== exp) begin nMismatched++; $display("FAIL stall_release_pc got v=%0h pc=%0h want v=1 pc=%0h", id_valid, id_pc, exp); end
      tick();
    end
  endtask

  task automatic test_redirect;
    applyReset(1'b0);
    repeat (4) tick();
    nCompared++; if (q_count !== 3'd3) begin nMismatched++; $display("FAIL redir_pre_count got %0d want 3", q_count); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    #1;
    nCompared++; if (imem_req !== 1'b0) begin nMismatched++; $display("FAIL redir_no_issue got %0h want 0", imem_req); end
    tick();
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    #1;
    nCompared++; if (id_valid !== 1'b0 || q_count !== 3'd0) begin nMismatched++; $display("FAIL redir_t1 got v=%0h cnt=%0d want v=0 cnt=0", id_valid, q_count); end
    nCompared++; if (imem_req !== 1'b1 || imem_addr !== 8'h40) begin nMismatched++; $display("FAIL redir_issue got req=%0h addr=%0h want req=1 addr=40", imem_req, imem_addr); end
    tick();
    nCompared++; if (id_valid !== 1'b0) begin nMismatched++; $display("FAIL redir_t2_valid got %0h want 0", id_valid); end
    tick();
    nCompared++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== 32'h140) begin nMismatched++; $display("FAIL redir_t3 got v=%0h pc=%0h ins=%0h want v=1 pc=40 ins=140", id_valid, id_pc, id_instr); end
    tick();
    nCompared++; if (id_valid !== 1'b1 || id_pc !== 32'h41) begin nMismatched++; $display("FAIL redir_t4 got v=%0h pc=%0h want v=1 pc=41", id_valid, id_pc); end
  endtask

  task automatic test_redirect_pop;
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    id_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    nCompared++; if (q_count !== 3'd0 || id_valid !== 1'b0) begin nMismatched++; $display("FAIL collide_empty got cnt=%0d v=%0h want cnt=0 v=0", q_count, id_valid); end
    tick();
    tick();
    nCompared++; if (id_valid !== 1'b1 || id_pc !== 32'h20 || id_next_pc !== 32'h21) begin nMismatched++; $display("FAIL collide_target got v=%0h pc=%0h nx=%0h want v=1 pc=20 nx=21", id_valid, id_pc, id_next_pc); end
  endtask

  task automatic test_wrap;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFE;
    tick();
    redirect_valid = 1'b0;
    #1;
    nCompared++; if (imem_req !== 1'b1 || imem_addr !== 8'hFE) begin nMismatched++; $display("FAIL wrap_addr0 got req=%0h addr=%0h want req=1 addr=fe", imem_req, imem_addr); end
    tick();
    nCompared++; if (imem_addr !== 8'hFF) begin nMismatched++; $display("FAIL wrap_addr1 got %0h want ff", imem_addr); end
    tick();
    nCompared++; if (imem_addr !== 8'h00) begin nMismatched++; $display("FAIL wrap_addr2 got %0h want 0", imem_addr); end
    nCompared++; if (id_pc !== 32'hFE || id_instr !== 32'h1FE) begin nMismatched++; $display("FAIL wrap_pc0 got pc=%0h ins=%0h want pc=fe ins=1fe", id_pc, id_instr); end
    tick();
    nCompared++; if (id_pc !== 32'hFF || id_instr !== 32'h1FF) begin nMismatched++; $display("FAIL wrap_pc1 got pc=%0h ins=%0h want pc=ff ins=1ff", id_pc, id_instr); end
    tick();
    nCompared++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== 32'h100 || id_next_pc !== 32'h101) begin nMismatched++; $display("FAIL wrap_pc2 got v=%0h pc=%0h ins=%0h nx=%0h want v=1 pc=100 ins=100 nx=101", id_valid, id_pc, id_instr, id_next_pc); end
  endtask

  task automatic test_mid_reset;
    applyReset(1'b0);
    repeat (4) tick();
    nCompared++; if (q_count !== 3'd3 || id_valid !== 1'b1) begin nMismatched++; $display("FAIL midrst_pre got cnt=%0d v=%0h want cnt=3 v=1", q_count, id_valid); end
    #2;
    clear = 1'b0;
    #1;
    nCompared++; if (id_valid !== 1'b0 || q_count !== 3'd0 || imem_req !== 1'b0) begin nMismatched++; $display("FAIL midrst_ctrl got v=%0h cnt=%0d req=%0h want all 0", id_valid, q_count, imem_req); end
    nCompared++; if (id_pc !== 32'h0 || id_instr !== 32'h0 || id_next_pc !== 32'h0 || imem_addr !== 8'h0) begin nMismatched++; $display("FAIL midrst_data got pc=%0h ins=%0h nx=%0h addr=%0h want all 0", id_pc, id_instr, id_next_pc, imem_addr); end
    tick();
    clear = 1'b1;
    id_ready = 1'b1;
    #1;
    nCompared++; if (imem_req !== 1'b1 || imem_addr !== 8'h0) begin nMismatched++; $display("FAIL midrst_restart got req=%0h addr=%0h want req=1 addr=0", imem_req, imem_addr); end
    tick();
    tick();
    nCompared++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h100) begin nMismatched++; $display("FAIL midrst_first got v=%0h pc=%0h ins=%0h want v=1 pc=0 ins=100", id_valid, id_pc, id_instr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_stall_fill();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
